// File: rtl/mem_byte_seq.sv
// ============================================================================
// Module   : mem_byte_seq
// Purpose  : Arbitrates fetch and load/store requests onto an 8-bit RAM bus,
//            splitting 1/2/4-byte accesses and reassembling read data.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_byte_seq #(
    parameter int          ADDR_W = 32,
    parameter logic [1:0]  IO_SEL = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ready,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic              if_done_o,
    output logic [31:0]       if_data_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_len_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic              mem_done_o,
    output logic [31:0]       mem_rdata_o,
    input  logic [7:0]        ram_din_i,
    output logic [7:0]        ram_dout_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic              ram_wr_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_ram_a;
    logic [1:0]          r_last;
    logic                r_is_if;
    logic [31:0]         r_wdata;
    logic [1:0]          r_ai;      // byte index currently on the bus
    logic                r_aval;    // bus address is a request the RAM should serve
    logic [1:0]          r_cap;     // oldest byte not yet captured
    logic                r_cv;      // ram_din_i holds byte r_cap this cycle
    logic                r_stl;     // a ready-low edge hit the read pipeline
    logic [31:0]         r_buf;
    logic [31:0]         r_if_data;
    logic [31:0]         r_mem_rdata;

    logic                w_accept;
    logic [ADDR_W-1:0]   w_req_addr;
    logic [1:0]          w_req_last;
    logic                w_flush;
    logic                w_cap;
    logic [31:0]         w_buf_next;
    logic [1:0]          w_cap_inc;
    logic [1:0]          w_ai_inc;
    logic                w_io;

    assign w_accept   = mem_req_i || (if_req_i && !if_flush_i);
    assign w_req_addr = mem_req_i ? mem_addr_i : if_addr_i;
    assign w_flush    = r_is_if && if_flush_i;
    assign w_cap      = r_cv && !r_stl;
    assign w_cap_inc  = r_cap + 2'd1;
    assign w_ai_inc   = r_ai + 2'd1;
    assign w_io       = (r_ram_a[17:16] == IO_SEL);

    always_comb begin
        w_req_last = 2'd3;
        if (mem_req_i) begin
            case (mem_len_i)
                2'd0:    w_req_last = 2'd0;
                2'd1:    w_req_last = 2'd1;
                default: w_req_last = 2'd3;
            endcase
        end
    end

    always_comb begin
        w_buf_next = r_buf;
        w_buf_next[{r_cap, 3'b000} +: 8] = ram_din_i;
    end

    always_comb begin
        w_next = r_state;
        if (ready) begin
            case (r_state)
                S_IDLE: begin
                    if (mem_req_i)
                        w_next = mem_we_i ? S_WR : S_RD;
                    else if (if_req_i && !if_flush_i)
                        w_next = S_RD;
                end
                S_RD: begin
                    if (w_flush)
                        w_next = S_IDLE;
                    else if (w_cap && (r_cap == r_last))
                        w_next = S_DONE;
                end
                S_WR: begin
                    if (r_ai == r_last)
                        w_next = S_DONE;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_ram_a     <= '0;
            r_last      <= 2'd0;
            r_is_if     <= 1'b0;
            r_wdata     <= 32'd0;
            r_ai        <= 2'd0;
            r_aval      <= 1'b0;
            r_cap       <= 2'd0;
            r_cv        <= 1'b0;
            r_stl       <= 1'b0;
            r_buf       <= 32'd0;
            r_if_data   <= 32'd0;
            r_mem_rdata <= 32'd0;
        end else if (ready) begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= w_req_addr;
                        r_ram_a <= w_req_addr;
                        r_last  <= w_req_last;
                        r_is_if <= !mem_req_i;
                        r_wdata <= mem_req_i ? mem_wdata_i : 32'd0;
                        r_ai    <= 2'd0;
                        r_aval  <= 1'b1;
                        r_cap   <= 2'd0;
                        r_cv    <= 1'b0;
                        r_stl   <= 1'b0;
                        r_buf   <= 32'd0;
                    end
                end
                S_RD: begin
                    if (w_flush) begin
                        r_aval <= 1'b0;
                        r_cv   <= 1'b0;
                    end else if (r_stl) begin
                        // Data in flight was lost while stalled: restart at r_cap.
                        r_stl <= 1'b0;
                        r_cv  <= 1'b1;
                        if (r_cap == r_last) begin
                            r_ai    <= r_cap;
                            r_aval  <= 1'b0;
                            r_ram_a <= r_addr + ADDR_W'(r_cap);
                        end else begin
                            r_ai    <= w_cap_inc;
                            r_aval  <= 1'b1;
                            r_ram_a <= r_addr + ADDR_W'(w_cap_inc);
                        end
                    end else begin
                        if (r_cv) begin
                            r_buf <= w_buf_next;
                            r_cap <= w_cap_inc;
                            if (r_cap == r_last) begin
                                if (r_is_if)
                                    r_if_data <= w_buf_next;
                                else
                                    r_mem_rdata <= w_buf_next;
                            end
                        end
                        r_cv <= r_aval;
                        if (r_aval) begin
                            if (r_ai == r_last) begin
                                r_aval <= 1'b0;
                            end else begin
                                r_ai    <= w_ai_inc;
                                r_ram_a <= r_addr + ADDR_W'(w_ai_inc);
                            end
                        end
                    end
                end
                S_WR: begin
                    if (r_ai != r_last) begin
                        r_ai    <= w_ai_inc;
                        r_ram_a <= r_addr + ADDR_W'(w_ai_inc);
                    end
                end
                default: begin
                end
            endcase
        end else if (r_state == S_RD) begin
            r_stl <= 1'b1;
        end
    end

    // Tail cycle of a read has no new request; avoid a second IO read.
    always_comb begin
        ram_a_o = '0;
        if (r_state == S_RD) begin
            if (r_stl && ready)
                ram_a_o = r_addr + ADDR_W'(r_cap);
            else if (!r_aval && w_io)
                ram_a_o = '0;
            else
                ram_a_o = r_ram_a;
        end else if (r_state == S_WR) begin
            ram_a_o = r_ram_a;
        end
    end

    assign ram_dout_o  = (r_state == S_WR) ? r_wdata[{r_ai, 3'b000} +: 8] : 8'd0;
    assign ram_wr_o    = (r_state == S_WR) && ready;
    assign if_done_o   = (r_state == S_DONE) && r_is_if && ready;
    assign mem_done_o  = (r_state == S_DONE) && !r_is_if && ready;
    assign if_data_o   = r_if_data;
    assign mem_rdata_o = r_mem_rdata;
    assign busy_o      = (r_state != S_IDLE);

endmodule

`default_nettype wire
